// File: rtl/alu_pkg.sv
// Shared types for the strobed-ALU sequencer: op codes, ALU select mapping, FSM states, status bit indices.
// Optional self-check build macro used by the sequencer: ALU_SEQ_SELFCHECK_EN.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_ADD = 2'b01,
        OP_MUL = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam int unsigned STAT_N = 2;
    localparam int unsigned STAT_C = 1;
    localparam int unsigned STAT_Z = 0;

    // ALU select lines {control[2], control[1]} for each operation
    function automatic logic [1:0] op_select(input op_t op);
        logic [1:0] sel;
        case (op)
            OP_ADD:  sel = 2'b01;
            OP_SUB:  sel = 2'b11;
            OP_MUL:  sel = 2'b10;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_flags.sv
// Combinational {N,C,Z} flag generation from operands and ALU result.
// With ALU_SEQ_SELFCHECK_EN defined it also produces the reference 8-bit result.
module alu_flags
    import alu_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] result,
`ifdef ALU_SEQ_SELFCHECK_EN
    output logic [7:0] expected,
`endif
    output logic [2:0] status
);

    op_t  op_e;
    logic carry;

    assign op_e = op_t'(op);

    always_comb begin
        carry = 1'b0;
        case (op_e)
            OP_ADD:  carry = (9'(a) + 9'(b)) > 9'd255;
            OP_SUB:  carry = a < b;
            OP_MUL:  carry = (16'(a) * 16'(b)) > 16'd255;
            default: carry = 1'b0;
        endcase
    end

    always_comb begin
        status         = '0;
        status[STAT_N] = result[7];
        status[STAT_C] = carry;
        status[STAT_Z] = (result == 8'd0);
    end

`ifdef ALU_SEQ_SELFCHECK_EN
    always_comb begin
        expected = '0;
        case (op_e)
            OP_ADD:  expected = a + b;
            OP_SUB:  expected = a - b;
            OP_MUL:  expected = a * b;
            default: expected = a | b;
        endcase
    end
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Request/response initiator for the 8-bit strobed ALU: SETUP -> STROBE -> CAPTURE -> RESP per op.
// Define ALU_SEQ_SELFCHECK_EN to compare alu_o against an internal reference and flag res_err.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [1:0]   op_code,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [W-1:0] alu_a1,
    output logic [W-1:0] alu_a2,
    output logic [2:0]   alu_control,
    input  logic [W-1:0] alu_o,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [2:0]   res_status,
    output logic         res_err
);

    state_t       state, state_next;
    op_t          op_reg;
    logic         strobe;
    logic [2:0]   flag_status;

`ifdef ALU_SEQ_SELFCHECK_EN
    logic [W-1:0] expected;
    logic         err_reg;
`endif

    alu_flags u_flags (
        .op       (op_reg),
        .a        (alu_a1),
        .b        (alu_a2),
        .result   (alu_o),
`ifdef ALU_SEQ_SELFCHECK_EN
        .expected (expected),
`endif
        .status   (flag_status)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (op_valid) state_next = S_SETUP;
            S_SETUP:   state_next = S_STROBE;
            S_STROBE:  state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_RESP;
            S_RESP:    if (res_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Strobe is registered off the next state so it is a clean one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            strobe     <= 1'b0;
            op_reg     <= OP_OR;
            alu_a1     <= '0;
            alu_a2     <= '0;
            res_data   <= '0;
            res_status <= '0;
        end else begin
            state  <= state_next;
            strobe <= (state_next == S_STROBE);
            if (state == S_IDLE && op_valid) begin
                alu_a1 <= op_a;
                alu_a2 <= op_b;
                op_reg <= op_t'(op_code);
            end
            if (state == S_CAPTURE) begin
                res_data   <= alu_o;
                res_status <= flag_status;
            end
        end
    end

`ifdef ALU_SEQ_SELFCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (state == S_CAPTURE) begin
            err_reg <= (alu_o != expected);
        end
    end
    assign res_err = err_reg;
`else
    assign res_err = 1'b0;
`endif

    assign op_ready    = (state == S_IDLE);
    assign res_valid   = (state == S_RESP);
    assign alu_control = {op_select(op_reg), strobe};

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural strobed-ALU model.
// Extra fault-injection step runs when ALU_SEQ_SELFCHECK_EN is defined.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [1:0] op_code = 2'b00;
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    logic [7:0] alu_a1, alu_a2;
    logic [2:0] alu_control;
    logic [7:0] alu_o = 8'd0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic [2:0] res_status;
    logic       res_err;

    int tests = 0;
    int fails = 0;
    int strobes = 0;
    bit fault_zero = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_a1      (alu_a1),
        .alu_a2      (alu_a2),
        .alu_control (alu_control),
        .alu_o       (alu_o),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_status  (res_status),
        .res_err     (res_err)
    );

    // Behavioural ALU: updates its output on the rising strobe
    always @(posedge alu_control[0]) begin
        strobes++;
        case (alu_control[2:1])
            2'b01:   alu_o <= alu_a1 + alu_a2;
            2'b11:   alu_o <= alu_a1 - alu_a2;
            2'b10:   alu_o <= alu_a1 * alu_a2;
            default: alu_o <= alu_a1 | alu_a2;
        endcase
        if (fault_zero) alu_o <= 8'd0;
    end

    function automatic logic [1:0] sel_of(input logic [1:0] code);
        case (code)
            2'b01:   return 2'b01;
            2'b11:   return 2'b11;
            2'b10:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [1:0] code, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input logic [2:0] exp_s,
                         input logic exp_err, input bit finish_resp);
        int s0;
        check({tag, ".ready"}, 16'(op_ready), 16'd1);
        s0 = strobes;
        op_valid = 1'b1;
        op_code  = code;
        op_a     = a;
        op_b     = b;
        tick();
        op_valid = 1'b0;
        op_a     = 8'h5A;
        op_b     = 8'hA5;
        check({tag, ".setup_strobe"}, 16'(alu_control[0]), 16'd0);
        check({tag, ".busy"}, 16'(op_ready), 16'd0);
        tick();
        check({tag, ".strobe_hi"}, 16'(alu_control[0]), 16'd1);
        check({tag, ".sel"}, 16'(alu_control[2:1]), 16'(sel_of(code)));
        check({tag, ".a1"}, 16'(alu_a1), 16'(a));
        check({tag, ".a2"}, 16'(alu_a2), 16'(b));
        tick();
        check({tag, ".strobe_lo"}, 16'(alu_control[0]), 16'd0);
        check({tag, ".no_resp_yet"}, 16'(res_valid), 16'd0);
        check({tag, ".one_pulse"}, 16'(strobes), 16'(s0 + 1));
        tick();
        check({tag, ".res_valid"}, 16'(res_valid), 16'd1);
        check({tag, ".data"}, 16'(res_data), 16'(exp_d));
        check({tag, ".status"}, 16'(res_status), 16'(exp_s));
        check({tag, ".err"}, 16'(res_err), 16'(exp_err));
        if (finish_resp) begin
            tick();
            check({tag, ".done"}, 16'(res_valid), 16'd0);
            check({tag, ".idle"}, 16'(op_ready), 16'd1);
        end
    endtask

    initial begin
        int s0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.op_ready", 16'(op_ready), 16'd1);
        check("rst.a1", 16'(alu_a1), 16'd0);
        check("rst.a2", 16'(alu_a2), 16'd0);
        check("rst.control", 16'(alu_control), 16'd0);
        check("rst.res_valid", 16'(res_valid), 16'd0);
        check("rst.data", 16'(res_data), 16'd0);
        check("rst.status", 16'(res_status), 16'd0);
        check("rst.err", 16'(res_err), 16'd0);
        rst_n = 1'b1;
        tick();

        do_op("add_200_100", 2'b01, 8'd200, 8'd100, 8'd44,  3'b010, 1'b0, 1'b1);
        do_op("sub_5_7",     2'b11, 8'd5,   8'd7,   8'hFE,  3'b110, 1'b0, 1'b1);
        do_op("sub_9_9",     2'b11, 8'd9,   8'd9,   8'h00,  3'b001, 1'b0, 1'b1);
        do_op("mul_16_16",   2'b10, 8'd16,  8'd16,  8'h00,  3'b011, 1'b0, 1'b1);
        do_op("or_0f_f0",    2'b00, 8'h0F,  8'hF0,  8'hFF,  3'b100, 1'b0, 1'b1);
        do_op("mul_7_9",     2'b10, 8'd7,   8'd9,   8'd63,  3'b000, 1'b0, 1'b1);

        // Response stall with a competing request that must not be taken
        res_ready = 1'b0;
        do_op("stall_add", 2'b01, 8'd3, 8'd4, 8'd7, 3'b000, 1'b0, 1'b0);
        s0 = strobes;
        for (int i = 0; i < 6; i++) begin
            op_valid = 1'b1;
            op_code  = 2'b11;
            op_a     = 8'd1;
            op_b     = 8'd2;
            tick();
            check("stall.valid", 16'(res_valid), 16'd1);
            check("stall.data", 16'(res_data), 16'd7);
            check("stall.status", 16'(res_status), 16'd0);
            check("stall.op_ready", 16'(op_ready), 16'd0);
            check("stall.no_strobe", 16'(strobes), 16'(s0));
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        check("stall.released", 16'(res_valid), 16'd0);
        check("stall.idle", 16'(op_ready), 16'd1);

        // Reset pulse while the strobe is high
        s0 = strobes;
        op_valid = 1'b1;
        op_code  = 2'b01;
        op_a     = 8'd10;
        op_b     = 8'd20;
        tick();
        op_valid = 1'b0;
        tick();
        check("rststb.strobe_hi", 16'(alu_control[0]), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rststb.control", 16'(alu_control), 16'd0);
        check("rststb.a1", 16'(alu_a1), 16'd0);
        check("rststb.res_valid", 16'(res_valid), 16'd0);
        check("rststb.op_ready", 16'(op_ready), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rststb.no_resp", 16'(res_valid), 16'd0);
        end
        check("rststb.pulses", 16'(strobes), 16'(s0 + 1));
        do_op("after_rst", 2'b01, 8'd10, 8'd20, 8'd30, 3'b000, 1'b0, 1'b1);

`ifdef ALU_SEQ_SELFCHECK_EN
        fault_zero = 1'b1;
        do_op("faulty_alu", 2'b01, 8'd1, 8'd1, 8'h00, 3'b001, 1'b1, 1'b1);
        fault_zero = 1'b0;
        do_op("good_alu", 2'b01, 8'd1, 8'd1, 8'h02, 3'b000, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Bus-side initiator for the 8-bit strobed ALU. Accepts one operation at a time over a valid/ready request channel and drives the ALU operand and control lines. It generates the rising-edge strobe on `control[0]` from the system clock, captures the ALU result, computes the status flags itself, and returns result plus flags over a valid/ready response channel. It sits between the datapath/decoder and the ALU, which it treats as a black-box responder.

## Interface
- `W`, default 8: operand/result width; only 8 is supported.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `op_valid`  in  1  request valid.
- `op_ready`  out  1  request ready; high only in IDLE.
- `op_code`  in  2  operation: 00 OR, 01 ADD, 10 MUL, 11 SUB.
- `op_a`, `op_b`  in  8  operands.
- `alu_a1`, `alu_a2`  out  8  ALU operands.
- `alu_control`  out  3  bit0 strobe; bits[2:1] select: ADD {0,1}, SUB {1,1}, MUL {1,0}, OR {0,0}, written as {bit2,bit1}.
- `alu_o`  in  8  ALU result.
- `res_valid`  out  1  response valid.
- `res_ready`  in  1  response ready.
- `res_data`  out  8  captured result.
- `res_status`  out  3  {N, C, Z}.
- `res_err`  out  1  self-check mismatch; see Configuration.

## Operation
- FSM states: IDLE, SETUP, STROBE, CAPTURE, RESP.
- IDLE: `op_ready`=1. On `op_valid`&&`op_ready`, register operands and op code. Next state is SETUP.
- SETUP: drive `alu_a1`/`alu_a2` and select bits with strobe=0. Next state is STROBE unconditionally.
- STROBE: strobe=1, which gives the ALU its posedge. Operands and select bits stay stable. Next state is CAPTURE.
- CAPTURE: strobe=0. Sample `alu_o` into `res_data` and flags into `res_status`. Next state is RESP.
- RESP: `res_valid`=1. On `res_ready` go to IDLE. Data and status stay stable while stalled.
- Operands and select bits hold their last values in IDLE. Only the strobe returns to 0.
- Flags are computed from the registered operands with 9-/16-bit internal arithmetic:
  - Z: `res_data`==0.
  - N: `res_data[7]`.
  - C, ADD: bit 8 of a+b.
  - C, SUB: borrow (a<b).
  - C, MUL: high byte of the 16-bit product is nonzero.
  - C, OR: 0.
- ADD, SUB and MUL results wrap modulo 256. MUL keeps the low byte.
- No request is accepted in RESP, so a new op costs one IDLE cycle minimum.

## Timing
- Reset values: `op_ready`=1, `alu_a1`=`alu_a2`=0, `alu_control`=000, `res_valid`=0, `res_data`=0, `res_status`=000, `res_err`=0. State is IDLE.
- Latency: request accepted at edge k gives strobe high after edge k+1, `res_valid` high after edge k+3.
- Throughput: one op per 5 cycles with `res_ready` tied high.
- The strobe is a registered output with a one-cycle high pulse. It never glitches and never pulses without a preceding SETUP cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately. The strobe falls, so no ALU posedge is generated, and the pending op is discarded with no response.
- `op_valid` dropping before acceptance is permitted. No request state is retained.

## Configuration
- `ALU_SEQ_SELFCHECK_EN` defined: the block computes the expected 8-bit result internally. In CAPTURE, `res_err` is set to (`alu_o` != expected) and held through RESP.
- Not defined: `res_err` is tied 0 and the reference computation is omitted. Flags are still computed.

## Structure
- Shared package `alu_pkg`:
  - op code enum and its mapping to `control[2:1]`;
  - FSM state enum;
  - status bit indices (N=2, C=1, Z=0).
- Sub-module `alu_flags`: combinational. Takes op code, operands and result; produces {N,C,Z} and, when self-check is enabled, the expected result.

## Test plan
- ADD 200+100 -> `res_data`=44, status N0 C1 Z0. Strobe is a single 1-cycle pulse 2 cycles after acceptance.
- SUB 5-7 -> 0xFE, N1 C1 Z0. SUB 9-9 -> 0x00, N0 C0 Z1.
- MUL 16*16 -> 0x00, N0 C1 Z1. OR 0x0F|0xF0 -> 0xFF, N1 C0 Z0.
- `res_ready` held low 6 cycles in RESP -> `res_valid`, data and status stable; `op_ready`=0; a second `op_valid` is not accepted until after the handshake.
- `rst_n` pulsed low during STROBE -> outputs at reset values within the same cycle, no response produced; a next op completes normally.
- With `ALU_SEQ_SELFCHECK_EN`: ALU model forced to return 0x00 on ADD 1+1 -> `res_err`=1 with `res_data`=0x00. A correct ALU gives `res_err`=0 on every op.
